aes64_enc_seq: RTL and testbench

AES64_ENC_SEQ -- requirements
Module: aes64_enc_seq

---
 rtl/aes64_enc_seq.sv | 176 +++++++++++++++++
 tb/tb_aes64_enc_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes64_enc_seq.sv
// AES-128 block encryptor that sequences a shared 64-bit AES functional unit.
// Each of the ten rounds uses five FU operations: two half-state encrypt steps,
// then three key-schedule steps. Cycle timing is set entirely by fu_ready.
module aes64_enc_seq (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_key,
  input  logic [127:0] req_pt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_ct,
  output logic         fu_valid,
  input  logic         fu_ready,
  output logic         fu_op_enc,
  output logic         fu_op_ks1,
  output logic         fu_op_ks2,
  output logic         fu_mix,
  output logic [63:0]  fu_rs1,
  output logic [63:0]  fu_rs2,
  output logic [3:0]   fu_rcon,
  input  logic [63:0]  fu_rd
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [63:0]  t_lo_q, t_lo_d;
  logic [63:0]  t_hi_q, t_hi_d;
  logic [63:0]  k_q, k_d;
  logic [3:0]   round_q, round_d;
  logic [2:0]   step_q, step_d;

  logic accept;
  logic fu_fire;
  logic last_op;

  assign accept  = (state_q == StIdle) && req_valid;
  assign fu_fire = (state_q == StRun) && fu_ready;
  assign last_op = (round_q == 4'd10) && (step_q == 3'd4);

  // FSM state register
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: requests outside IDLE are simply not seen
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = StRun;
      StRun:   if (fu_ready && last_op) state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: load on accept, capture fu_rd only on an FU handshake
  always_comb begin
    st_d    = st_q;
    rk_d    = rk_q;
    t_lo_d  = t_lo_q;
    t_hi_d  = t_hi_q;
    k_d     = k_q;
    round_d = round_q;
    step_d  = step_q;
    if (accept) begin
      st_d    = req_pt ^ req_key;
      rk_d    = req_key;
      round_d = 4'd1;
      step_d  = 3'd0;
    end else if (fu_fire) begin
      step_d = step_q + 3'd1;
      case (step_q)
        3'd0: t_lo_d = fu_rd;
        3'd1: t_hi_d = fu_rd;
        3'd2: k_d = fu_rd;
        3'd3: rk_d[63:0] = fu_rd;
        3'd4: begin
          // fu_rd is the new rk.hi; rk_q[63:0] already holds the new rk.lo
          rk_d[127:64] = fu_rd;
          st_d         = {t_hi_q ^ fu_rd, t_lo_q ^ rk_q[63:0]};
          step_d       = 3'd0;
          // Round stays at 10 once the last round completes
          if (round_q != 4'd10) round_d = round_q + 4'd1;
        end
        default: step_d = 3'd0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      st_q    <= '0;
      rk_q    <= '0;
      t_lo_q  <= '0;
      t_hi_q  <= '0;
      k_q     <= '0;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      st_q    <= st_d;
      rk_q    <= rk_d;
      t_lo_q  <= t_lo_d;
      t_hi_q  <= t_hi_d;
      k_q     <= k_d;
      round_q <= round_d;
      step_q  <= step_d;
    end
  end

  // Outputs decoded from registered state only, so they hold across FU stalls
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_ct    = '0;
    fu_valid  = 1'b0;
    fu_op_enc = 1'b0;
    fu_op_ks1 = 1'b0;
    fu_op_ks2 = 1'b0;
    fu_mix    = 1'b0;
    fu_rs1    = '0;
    fu_rs2    = '0;
    fu_rcon   = '0;
    case (state_q)
      StIdle: req_ready = 1'b1;
      StDone: begin
        rsp_valid = 1'b1;
        rsp_ct    = st_q;
      end
      StRun: begin
        fu_valid = 1'b1;
        case (step_q)
          3'd0: begin
            fu_op_enc = 1'b1;
            fu_mix    = (round_q != 4'd10);
            fu_rs1    = st_q[63:0];
            fu_rs2    = st_q[127:64];
          end
          3'd1: begin
            fu_op_enc = 1'b1;
            fu_mix    = (round_q != 4'd10);
            fu_rs1    = st_q[127:64];
            fu_rs2    = st_q[63:0];
          end
          3'd2: begin
            fu_op_ks1 = 1'b1;
            fu_rs1    = rk_q[127:64];
            fu_rcon   = round_q - 4'd1;
          end
          3'd3: begin
            fu_op_ks2 = 1'b1;
            fu_rs1    = k_q;
            fu_rs2    = rk_q[63:0];
          end
          3'd4: begin
            fu_op_ks2 = 1'b1;
            fu_rs1    = rk_q[63:0];
            fu_rs2    = rk_q[127:64];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes64_enc_seq.sv
// Bench for aes64_enc_seq: drives the FU port from a saes64 reference model
// and checks FIPS-197 vectors, operation sequencing, stalls, backpressure and reset.
module tb_aes64_enc_seq;

  typedef logic [135:0] v_t;

  logic         g_clk = 1'b0;
  logic         g_resetn;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_pt;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_ct;
  logic         fu_valid;
  logic         fu_ready;
  logic         fu_op_enc;
  logic         fu_op_ks1;
  logic         fu_op_ks2;
  logic         fu_mix;
  logic [63:0]  fu_rs1;
  logic [63:0]  fu_rs2;
  logic [3:0]   fu_rcon;
  logic [63:0]  fu_rd;

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  aes64_enc_seq dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_pt    (req_pt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ct    (rsp_ct),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_op_enc (fu_op_enc),
    .fu_op_ks1 (fu_op_ks1),
    .fu_op_ks2 (fu_op_ks2),
    .fu_mix    (fu_mix),
    .fu_rs1    (fu_rs1),
    .fu_rs2    (fu_rs2),
    .fu_rcon   (fu_rcon),
    .fu_rd     (fu_rd)
  );

  task automatic chk(input string tag, input v_t got, input v_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- saes64 reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, p, e;
    inv = 8'h01;
    p   = x;
    e   = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, p);
      p = gmul(p, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [63:0] fu_model(input logic enc, input logic ks1, input logic ks2,
                                           input logic mix, input logic [3:0] rcon,
                                           input logic [63:0] rs1, input logic [63:0] rs2);
    logic [127:0] s;
    logic [63:0]  r;
    logic [31:0]  w;
    logic [7:0]   rc, a0, a1, a2, a3;
    r = '0;
    if (enc) begin
      s = {rs2, rs1};
      for (int c = 0; c < 2; c++)
        for (int row = 0; row < 4; row++)
          r[8*(4*c+row) +: 8] = sbox(s[8*(4*((c+row)%4)+row) +: 8]);
      if (mix) begin
        for (int c = 0; c < 2; c++) begin
          a0 = r[32*c +: 8];
          a1 = r[32*c+8 +: 8];
          a2 = r[32*c+16 +: 8];
          a3 = r[32*c+24 +: 8];
          r[32*c +: 8]    = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          r[32*c+8 +: 8]  = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          r[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          r[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
    end else if (ks1) begin
      w = rs1[63:32];
      if (rcon != 4'd10) w = {w[7:0], w[31:8]};
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sbox(w[8*i +: 8]);
      rc = 8'h01;
      for (int i = 0; i < int'(rcon); i++) rc = gmul(rc, 8'h02);
      if (rcon != 4'd10) w[7:0] = w[7:0] ^ rc;
      r = {w, w};
    end else if (ks2) begin
      r[31:0]  = rs1[63:32] ^ rs2[31:0];
      r[63:32] = rs1[63:32] ^ rs2[63:32] ^ rs2[31:0];
    end
    return r;
  endfunction

  always_comb fu_rd = fu_model(fu_op_enc, fu_op_ks1, fu_op_ks2, fu_mix, fu_rcon, fu_rs1, fu_rs2);

  // FU handshake driver: optional random 0-5 cycle stall per operation
  bit stall_en = 1'b0;
  initial begin : fu_driver
    int cnt;
    bit have_cnt;
    fu_ready = 1'b0;
    cnt      = 0;
    have_cnt = 1'b0;
    forever begin
      @(posedge g_clk);
      #1;
      if (!fu_valid) begin
        fu_ready = 1'b0;
      end else begin
        if (!have_cnt) begin
          cnt      = stall_en ? int'($urandom_range(0, 5)) : 0;
          have_cnt = 1'b1;
        end
        if (cnt == 0) begin
          fu_ready = 1'b1;
          have_cnt = 1'b0;
        end else begin
          fu_ready = 1'b0;
          cnt--;
        end
      end
    end
  end

  // Expected {enc, ks1, ks2, mix, rcon} for the idx-th operation of a run
  function automatic logic [7:0] exp_ctrl(input int idx);
    int r, s;
    logic [7:0] e;
    r = idx / 5 + 1;
    s = idx % 5;
    e = 8'h00;
    if (s < 2) begin
      e[7] = 1'b1;
      e[4] = (r < 10);
    end else if (s == 2) begin
      e[6]   = 1'b1;
      e[3:0] = 4'(r - 1);
    end else begin
      e[5] = 1'b1;
    end
    return e;
  endfunction

  // FU monitor: per-handshake op sequencing and stall stability
  bit   mon_en = 1'b0;
  int   hs_cnt = 0;
  bit   stalled_prev = 1'b0;
  v_t   fu_snap = '0;
  logic [7:0] ctrl;
  v_t   fu_vec;
  assign ctrl   = {fu_op_enc, fu_op_ks1, fu_op_ks2, fu_mix, fu_rcon};
  assign fu_vec = {ctrl, fu_rs1, fu_rs2};

  always @(negedge g_clk) begin
    if (mon_en) begin
      if (stalled_prev && fu_valid) chk("fu_stable_in_stall", fu_vec, fu_snap);
      if (fu_valid && fu_ready) begin
        chk("fu_op_ctrl", v_t'(ctrl), v_t'(exp_ctrl(hs_cnt)));
        hs_cnt = hs_cnt + 1;
      end
    end
    stalled_prev = fu_valid && !fu_ready;
    fu_snap      = fu_vec;
  end

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  task automatic issue(input logic [127:0] key, input logic [127:0] pt);
    int n;
    @(negedge g_clk);
    req_key   = key;
    req_pt    = pt;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge g_clk);
      n++;
    end
    chk("req_ready_wait", v_t'(req_ready), v_t'(1));
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [127:0] ct, output int lat);
    lat = 0;
    do begin
      @(negedge g_clk);
      lat++;
    end while (!rsp_valid && lat < 3000);
    chk("rsp_valid_seen", v_t'(rsp_valid), v_t'(1));
    ct = rsp_ct;
  endtask

  task automatic consume();
    @(negedge g_clk);
    rsp_ready = 1'b1;
    @(posedge g_clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  logic [127:0] k1, p1, c1, k2, p2, c2, ct;
  int lat;

  initial begin
    k1 = bswap(128'h000102030405060708090a0b0c0d0e0f);
    p1 = bswap(128'h00112233445566778899aabbccddeeff);
    c1 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    k2 = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
    p2 = bswap(128'h3243f6a8885a308d313198a2e0370734);
    c2 = bswap(128'h3925841d02dc09fbdc118597196a0b32);

    // Reset with inputs idle
    g_resetn  = 1'b0;
    req_valid = 1'b0;
    req_key   = '0;
    req_pt    = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge g_clk);
    chk("rst_flags", v_t'({req_ready, rsp_valid, fu_valid}), v_t'(3'b100));
    chk("rst_ct", v_t'(rsp_ct), v_t'(0));
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("post_rst_flags", v_t'({req_ready, rsp_valid, fu_valid}), v_t'(3'b100));

    // Zero-wait FU, FIPS-197 C.1
    mon_en = 1'b1;
    hs_cnt = 0;
    issue(k1, p1);
    wait_rsp(ct, lat);
    chk("c1_ct", v_t'(ct), v_t'(c1));
    chk("c1_latency", v_t'(lat), v_t'(51));
    chk("c1_handshakes", v_t'(hs_cnt), v_t'(50));
    consume();

    // Random FU stalls, FIPS-197 appendix B
    stall_en = 1'b1;
    hs_cnt   = 0;
    issue(k2, p2);
    wait_rsp(ct, lat);
    chk("b_ct_stall", v_t'(ct), v_t'(c2));
    chk("b_handshakes", v_t'(hs_cnt), v_t'(50));
    consume();
    stall_en = 1'b0;

    // Response backpressure with a request waiting
    hs_cnt = 0;
    issue(k1, p1);
    wait_rsp(ct, lat);
    chk("bp_ct", v_t'(ct), v_t'(c1));
    req_key   = k2;
    req_pt    = p2;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      chk("bp_hold_ct", v_t'(rsp_ct), v_t'(c1));
      chk("bp_hold_flags", v_t'({req_ready, rsp_valid, fu_valid}), v_t'(3'b010));
    end
    chk("bp_no_fu", v_t'(hs_cnt), v_t'(50));
    rsp_ready = 1'b1;
    hs_cnt    = 0;
    @(posedge g_clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge g_clk);
    chk("bp_ready_after_rsp", v_t'({req_ready, rsp_valid}), v_t'(2'b10));
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(ct, lat);
    chk("bp_next_ct", v_t'(ct), v_t'(c2));
    chk("bp_next_latency", v_t'(lat), v_t'(51));
    consume();

    // Reset during round 5, step 3 (op index 23, presented in cycle 24)
    hs_cnt = 0;
    issue(k1, p1);
    repeat (24) @(negedge g_clk);
    chk("mid_op_ks2", v_t'({fu_valid, ctrl}), v_t'(9'h120));
    mon_en   = 1'b0;
    g_resetn = 1'b0;
    #1;
    chk("mid_rst_flags",
        v_t'({req_ready, rsp_valid, fu_valid, fu_op_enc, fu_op_ks1, fu_op_ks2, fu_mix, fu_rcon}),
        v_t'(11'h400));
    chk("mid_rst_ct", v_t'(rsp_ct), v_t'(0));
    chk("mid_rst_rs", v_t'({fu_rs1, fu_rs2}), v_t'(0));
    repeat (2) @(negedge g_clk);
    chk("mid_rst_no_rsp", v_t'(rsp_valid), v_t'(0));
    g_resetn = 1'b1;
    mon_en   = 1'b1;
    hs_cnt   = 0;
    issue(k1, p1);
    wait_rsp(ct, lat);
    chk("after_rst_ct", v_t'(ct), v_t'(c1));
    chk("after_rst_latency", v_t'(lat), v_t'(51));
    chk("after_rst_handshakes", v_t'(hs_cnt), v_t'(50));
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
